ptw_resp_cache: RTL and testbench

- Parametrised successor to the two-entry PTW response tag store in the TLB path.
- Accepts page-table-walker responses from NCH requester channels (e.g. imem, dmem) through a round-robin arbiter.
- Caches translations in an ENTRIES-deep fully associative array and answers VPN lookups with registered hit/ppn/error.
- Adds behaviour the old store lacks: tag matching, valid bits, replacement, flush and an occupancy count.

---
 rtl/ptw_resp_cache.sv | 171 +++++++++++++++++
 tb/tb_ptw_resp_cache.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_resp_cache.sv
// PTW response cache: round-robin intake of walker responses into a fully
// associative translation array, with registered VPN lookup, flush and occupancy.
module ptw_resp_cache #(
  parameter int NCH     = 2,
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 32,
  localparam int OCC_W  = $clog2(ENTRIES + 1),
  localparam int RR_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int VP_W   = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         ptw_valid,
  output logic [NCH-1:0]         ptw_ready,
  input  logic [NCH-1:0]         ptw_error,
  input  logic [NCH*VPN_W-1:0]   ptw_vpn,
  input  logic [NCH*PPN_W-1:0]   ptw_ppn,
  input  logic                   lookup_valid,
  input  logic [VPN_W-1:0]       lookup_vpn,
  input  logic                   flush,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_error,
  output logic [PPN_W-1:0]       resp_ppn,
  output logic [OCC_W-1:0]       occupancy
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] err_q;
  logic [VPN_W-1:0]   tag_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [RR_W-1:0]    rr_q, rr_d;
  logic [VP_W-1:0]    vp_q, vp_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic               resp_valid_q, resp_hit_q, resp_error_q;
  logic [PPN_W-1:0]   resp_ppn_q;

  logic               gnt_any;
  logic [RR_W-1:0]    gnt_idx;
  logic [RR_W-1:0]    scan_idx;
  int                 scan_c;
  logic               xfer;
  logic [VPN_W-1:0]   wr_vpn;
  logic [PPN_W-1:0]   wr_ppn;
  logic               wr_err;
  logic               wr_hit, free_any, wr_en;
  logic [VP_W-1:0]    wr_hit_idx, free_idx, wr_idx;
  logic               lk_hit, lk_err;
  logic [PPN_W-1:0]   lk_ppn;

  // Handshake: a response moves on channel i when ptw_valid[i] & ptw_ready[i]
  // at a rising edge; ready is a pure grant (never back-pressured by fullness).
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_c   = 0;
    scan_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_c = int'(rr_q) + k;
      if (scan_c >= NCH) scan_c = scan_c - NCH;
      scan_idx = RR_W'(scan_c);
      if (!gnt_any && ptw_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ptw_ready = '0;
    if (gnt_any && !flush && reset_n) ptw_ready[gnt_idx] = 1'b1;
  end

  assign xfer   = |(ptw_valid & ptw_ready);
  assign wr_vpn = ptw_vpn[int'(gnt_idx)*VPN_W +: VPN_W];
  assign wr_ppn = ptw_ppn[int'(gnt_idx)*PPN_W +: PPN_W];
  assign wr_err = ptw_error[gnt_idx];

  // Tags are unique by construction, so OR-reducing matches is safe.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_any   = 1'b0;
    free_idx   = '0;
    lk_hit     = 1'b0;
    lk_err     = 1'b0;
    lk_ppn     = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (valid_q[e] && tag_q[e] == wr_vpn) begin
        wr_hit     = 1'b1;
        wr_hit_idx = VP_W'(e);
      end
      if (!valid_q[e] && !free_any) begin
        free_any = 1'b1;
        free_idx = VP_W'(e);
      end
      if (valid_q[e] && tag_q[e] == lookup_vpn) begin
        lk_hit = 1'b1;
        lk_err = lk_err | err_q[e];
        lk_ppn = lk_ppn | ppn_q[e];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    vp_d    = vp_q;
    occ_d   = occ_q;
    rr_d    = rr_q;
    wr_idx  = vp_q;
    wr_en   = 1'b0;
    if (flush) begin
      valid_d = '0;
      vp_d    = '0;
      occ_d   = '0;
    end else if (xfer) begin
      wr_en = 1'b1;
      rr_d  = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      if (wr_hit) begin
        wr_idx = wr_hit_idx;
      end else if (free_any) begin
        wr_idx = free_idx;
        occ_d  = occ_q + 1'b1;
      end else begin
        wr_idx = vp_q;
        vp_d   = (int'(vp_q) == ENTRIES - 1) ? '0 : vp_q + 1'b1;
      end
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_vpn;
      ppn_q[wr_idx] <= wr_ppn;
      err_q[wr_idx] <= wr_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      rr_q         <= '0;
      vp_q         <= '0;
      occ_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_error_q <= 1'b0;
      resp_ppn_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      vp_q         <= vp_d;
      occ_q        <= occ_d;
      resp_valid_q <= lookup_valid;
      resp_hit_q   <= lookup_valid & lk_hit;
      resp_error_q <= lookup_valid & lk_err;
      resp_ppn_q   <= lookup_valid ? lk_ppn : '0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_error = resp_error_q;
  assign resp_ppn   = resp_ppn_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_ptw_resp_cache.sv
// Bench for ptw_resp_cache: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an entry-list model.
`timescale 1ns/1ps
module tb_ptw_resp_cache;
  localparam int NCH     = 2;
  localparam int ENTRIES = 4;
  localparam int VPN_W   = 20;
  localparam int PPN_W   = 32;
  localparam int OCC_W   = 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic [NCH-1:0]       ptw_valid = '0;
  logic [NCH-1:0]       ptw_ready;
  logic [NCH-1:0]       ptw_error = '0;
  logic [NCH*VPN_W-1:0] ptw_vpn = '0;
  logic [NCH*PPN_W-1:0] ptw_ppn = '0;
  logic                 lookup_valid = 1'b0;
  logic [VPN_W-1:0]     lookup_vpn = '0;
  logic                 flush = 1'b0;
  logic                 resp_valid, resp_hit, resp_error;
  logic [PPN_W-1:0]     resp_ppn;
  logic [OCC_W-1:0]     occupancy;

  ptw_resp_cache #(.NCH(NCH), .ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ptw_valid(ptw_valid), .ptw_ready(ptw_ready), .ptw_error(ptw_error),
    .ptw_vpn(ptw_vpn), .ptw_ppn(ptw_ppn),
    .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn), .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_error(resp_error),
    .resp_ppn(resp_ppn), .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a list of cached translations
  bit               m_valid [ENTRIES];
  logic [VPN_W-1:0] m_tag   [ENTRIES];
  logic [PPN_W-1:0] m_ppn   [ENTRIES];
  bit               m_err   [ENTRIES];
  int               m_rr, m_vp;
  bit               e_rv, e_hit, e_err;
  logic [PPN_W-1:0] e_ppn;

  function automatic int m_count();
    int n = 0;
    for (int e = 0; e < ENTRIES; e++) if (m_valid[e]) n++;
    return n;
  endfunction

  task automatic model_write(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p, input bit er);
    int idx;
    idx = -1;
    for (int e = 0; e < ENTRIES; e++) if (m_valid[e] && m_tag[e] == v) idx = e;
    if (idx < 0) for (int e = 0; e < ENTRIES; e++) if (!m_valid[e] && idx < 0) idx = e;
    if (idx < 0) begin
      idx  = m_vp;
      m_vp = (m_vp + 1) % ENTRIES;
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = v;
    m_ppn[idx]   = p;
    m_err[idx]   = er;
  endtask

  // scoreboard: checks every cycle at the falling edge, then advances the model
  always @(negedge clk) begin : cmp
    int g;
    int c;
    logic [NCH-1:0] er;
    if (!reset_n) begin
      for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
      m_rr = 0; m_vp = 0;
      e_rv = 1'b0; e_hit = 1'b0; e_err = 1'b0; e_ppn = '0;
      chk("rst_ptw_ready", ptw_ready, '0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_ppn", resp_ppn, 0);
      chk("rst_occupancy", occupancy, 0);
    end else begin
      g = -1;
      if (!flush) begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (g < 0 && ptw_valid[c]) g = c;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ptw_ready", ptw_ready, er);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_hit", resp_hit, e_hit);
      chk("resp_error", resp_error, e_err);
      chk("resp_ppn", resp_ppn, e_ppn);
      chk("occupancy", occupancy, m_count());
      e_rv = lookup_valid; e_hit = 1'b0; e_err = 1'b0; e_ppn = '0;
      if (lookup_valid) begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (m_valid[e] && m_tag[e] == lookup_vpn) begin
            e_hit = 1'b1; e_err = m_err[e]; e_ppn = m_ppn[e];
          end
        end
      end
      if (flush) begin
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
        m_vp = 0;
      end else if (g >= 0) begin
        m_rr = (g + 1) % NCH;
        model_write(ptw_vpn[g*VPN_W +: VPN_W], ptw_ppn[g*PPN_W +: PPN_W], ptw_error[g]);
      end
    end
  end

  // driver tasks
  task automatic idle();
    ptw_valid = '0; ptw_error = '0; lookup_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p, input bit er);
    ptw_valid[c] = 1'b1;
    ptw_error[c] = er;
    ptw_vpn[c*VPN_W +: VPN_W] = v;
    ptw_ppn[c*PPN_W +: PPN_W] = p;
  endtask

  task automatic look(input logic [VPN_W-1:0] v);
    lookup_valid = 1'b1; lookup_vpn = v;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fin();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    #1 reset_n = 1'b0;
    ptw_valid = 2'b11;
    mid();
    chk("lit_ready_in_reset", ptw_ready, 2'b00);
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // miss after reset
    idle(); look(20'h12); mid(); fin();
    idle(); mid();
    chk("lit_miss_valid", resp_valid, 1); chk("lit_miss_hit", resp_hit, 0);
    chk("lit_miss_ppn", resp_ppn, 0); chk("lit_miss_err", resp_error, 0);
    chk("lit_miss_occ", occupancy, 0);
    fin();

    // write, hit, overwrite
    idle(); set_ch(0, 20'h12, 32'hABCD0000, 1'b0); mid();
    chk("lit_wr_ready", ptw_ready, 2'b01); fin();
    idle(); look(20'h12); mid(); fin();
    idle(); mid();
    chk("lit_hit", resp_hit, 1); chk("lit_hit_ppn", resp_ppn, 32'hABCD0000);
    chk("lit_hit_occ", occupancy, 1); fin();
    idle(); set_ch(0, 20'h12, 32'h1, 1'b0); mid(); fin();
    idle(); look(20'h12); mid(); chk("lit_ovw_occ", occupancy, 1); fin();
    idle(); mid(); chk("lit_ovw_ppn", resp_ppn, 32'h1); fin();

    // round-robin alternation from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); set_ch(0, 20'h100, 32'h100, 1'b0); set_ch(1, 20'h200, 32'h200, 1'b0);
      mid();
      chk("lit_rr_grant", ptw_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      fin();
    end

    // fill and replace
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      idle(); set_ch(0, 20'(v), 32'h1000 + 32'(v), 1'b0); mid(); fin();
    end
    idle(); set_ch(0, 20'd5, 32'h1005, 1'b0); mid(); chk("lit_full_occ", occupancy, 4); fin();
    idle(); look(20'd1); mid(); fin();
    idle(); look(20'd5); mid(); chk("lit_evict1_miss", resp_hit, 0); fin();
    idle(); mid(); chk("lit_new5_hit", resp_hit, 1); chk("lit_new5_ppn", resp_ppn, 32'h1005);
    chk("lit_full_occ2", occupancy, 4); fin();
    idle(); set_ch(0, 20'd6, 32'h1006, 1'b0); mid(); fin();
    idle(); look(20'd2); mid(); fin();
    idle(); mid(); chk("lit_evict2_miss", resp_hit, 0); fin();

    // same-cycle lookup and write
    idle(); set_ch(1, 20'd7, 32'h7777, 1'b1); look(20'd7); mid();
    chk("lit_ch1_ready", ptw_ready, 2'b10); fin();
    idle(); look(20'd7); mid(); chk("lit_rbw_miss", resp_hit, 0); fin();
    idle(); mid(); chk("lit_rbw_hit", resp_hit, 1); chk("lit_rbw_err", resp_error, 1);
    chk("lit_rbw_ppn", resp_ppn, 32'h7777); fin();

    // flush with concurrent write and lookup
    idle(); set_ch(0, 20'd5, 32'h5555, 1'b0); look(20'd5); flush = 1'b1; mid();
    chk("lit_flush_ready", ptw_ready, 2'b00); fin();
    idle(); look(20'd5); mid();
    chk("lit_flush_prehit", resp_hit, 1); chk("lit_flush_preppn", resp_ppn, 32'h1005);
    chk("lit_flush_occ", occupancy, 0); fin();
    idle(); mid(); chk("lit_flush_miss", resp_hit, 0); fin();

    // async reset between lookup and response
    idle(); set_ch(0, 20'd9, 32'h99, 1'b0); mid(); fin();
    idle(); look(20'd9); mid();
    #2 reset_n = 1'b0;
    #1 chk("lit_async_rv", resp_valid, 0);
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); mid(); chk("lit_async_hold", resp_valid, 0); fin();
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 99) < 50)
          set_ch(c, 20'($urandom_range(0, 9)), $urandom, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) < 50) look(20'($urandom_range(0, 9)));
      flush = ($urandom_range(0, 39) == 0);
      mid(); fin();
    end

    idle(); mid(); fin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
